// File: rtl/arb_pkg.sv
// Shared definitions for the memory-port arbiter: FSM states, requester
// indices and the default stall limit.
package arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: a sole requester always wins; on a tie the
// requester that did not win last time goes first.
module rr_pick2
    import arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic any,
    output logic winner
);

    always_comb begin
        any = req0 | req1;
        if (req0 && req1) begin
            winner = ~last;
        end else if (req1) begin
            winner = REQ_DM;
        end else begin
            winner = REQ_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of one shared memory port for instruction fetch (0) and
// data access (1), one transaction per grant, with a stall abort.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no access in flight; arbitrate, sel holds the last owner
// ST_BUSY | access latched for requester sel; wait for mem_ready or abort
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic we0,
    input  logic req1,
    input  logic we1,
    input  logic mem_ready,
    output logic sel,
    output logic mem_en,
    output logic mem_we,
    output logic gnt0,
    output logic gnt1,
    output logic done0,
    output logic done1,
    output logic timeout
);

    localparam bit               TO_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t           state, state_nxt;
    logic             last, last_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             sel_nxt, gnt0_nxt, gnt1_nxt, en_nxt, we_nxt, timeout_nxt;
    logic             any, winner;

    rr_pick2 u_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (last),
        .any    (any),
        .winner (winner)
    );

    always_comb begin
        state_nxt   = state;
        sel_nxt     = sel;
        last_nxt    = last;
        cnt_nxt     = cnt;
        gnt0_nxt    = gnt0;
        gnt1_nxt    = gnt1;
        en_nxt      = mem_en;
        we_nxt      = mem_we;
        timeout_nxt = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (any) begin
                    state_nxt = ST_BUSY;
                    sel_nxt   = winner;
                    gnt0_nxt  = (winner == REQ_IF);
                    gnt1_nxt  = (winner == REQ_DM);
                    en_nxt    = 1'b1;
                    we_nxt    = (winner == REQ_DM) ? we1 : we0;
                    cnt_nxt   = '0;
                end
            end
            ST_BUSY: begin
                // Completion takes priority over an abort in the same cycle.
                if (mem_ready || (TO_EN && cnt == TO_LAST)) begin
                    state_nxt   = ST_IDLE;
                    gnt0_nxt    = 1'b0;
                    gnt1_nxt    = 1'b0;
                    en_nxt      = 1'b0;
                    we_nxt      = 1'b0;
                    last_nxt    = sel;
                    timeout_nxt = ~mem_ready;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            sel     <= 1'b0;
            last    <= 1'b1;
            cnt     <= '0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            sel     <= sel_nxt;
            last    <= last_nxt;
            cnt     <= cnt_nxt;
            gnt0    <= gnt0_nxt;
            gnt1    <= gnt1_nxt;
            mem_en  <= en_nxt;
            mem_we  <= we_nxt;
            timeout <= timeout_nxt;
        end
    end

    assign done0 = gnt0 & mem_ready;
    assign done1 = gnt1 & mem_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 4-cycle stall limit; outputs are
// packed as {gnt0,gnt1,sel,mem_en,mem_we,done0,done1,timeout}.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0, mem_ready = 1'b0;
    logic sel, mem_en, mem_we, gnt0, gnt1, done0, done1, timeout;
    logic [7:0] obs;
    int n_pass = 0;
    int n_total = 0;

    mem_port_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .we0       (we0),
        .req1      (req1),
        .we1       (we1),
        .mem_ready (mem_ready),
        .sel       (sel),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    assign obs = {gnt0, gnt1, sel, mem_en, mem_we, done0, done1, timeout};

    // Advance one rising edge, then settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        #1;
        n_total++;
        if (obs !== 8'b0000_0000) $display("FAIL reset_state: got %b want %b", obs, 8'b0000_0000);
        else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        req0 = 1'b1; we0 = 1'b0; mem_ready = 1'b0;
        #1;
        n_total++;
        if (mem_en !== 1'b0) $display("FAIL read_no_en_same_cycle: got %b want 0", mem_en);
        else n_pass++;
        tick(); #1;
        n_total++;
        if (obs !== 8'b1001_0000) $display("FAIL read_busy1: got %b want %b", obs, 8'b1001_0000);
        else n_pass++;
        tick(); #1;
        n_total++;
        if (obs !== 8'b1001_0000) $display("FAIL read_busy2: got %b want %b", obs, 8'b1001_0000);
        else n_pass++;
        tick();
        mem_ready = 1'b1;
        #1;
        n_total++;
        if (obs !== 8'b1001_0100) $display("FAIL read_done_busy3: got %b want %b", obs, 8'b1001_0100);
        else n_pass++;
        req0 = 1'b0;
        tick();
        mem_ready = 1'b0;
        #1;
        n_total++;
        if (obs !== 8'b0000_0000) $display("FAIL read_idle_after: got %b want %b", obs, 8'b0000_0000);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_busy, exp_idle;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req0 = 1'b1; we0 = 1'b0; req1 = 1'b1; we1 = 1'b1; mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_busy = (k % 2 == 0) ? 8'b1001_0100 : 8'b0111_1010;
            exp_idle = (k % 2 == 0) ? 8'b0000_0000 : 8'b0010_0000;
            tick(); #1;
            n_total++;
            if (obs !== exp_busy) $display("FAIL rr_busy_%0d: got %b want %b", k, obs, exp_busy);
            else n_pass++;
            tick(); #1;
            n_total++;
            if (obs !== exp_idle) $display("FAIL rr_idle_%0d: got %b want %b", k, obs, exp_idle);
            else n_pass++;
        end
        req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b0;
        tick(); #1;
        n_total++;
        if (obs !== 8'b0010_0000) $display("FAIL rr_quiet: got %b want %b", obs, 8'b0010_0000);
        else n_pass++;
    endtask

    task automatic test_timeout();
        req1 = 1'b1; we1 = 1'b1; mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            n_total++;
            if (obs !== 8'b0111_1000) $display("FAIL to_busy_%0d: got %b want %b", k, obs, 8'b0111_1000);
            else n_pass++;
        end
        tick();
        req1 = 1'b0;
        #1;
        n_total++;
        if (obs !== 8'b0010_0001) $display("FAIL to_pulse: got %b want %b", obs, 8'b0010_0001);
        else n_pass++;
        tick(); #1;
        n_total++;
        if (obs !== 8'b0010_0000) $display("FAIL to_pulse_end_sel_hold: got %b want %b", obs, 8'b0010_0000);
        else n_pass++;
    endtask

    task automatic test_ready_vs_timeout();
        req0 = 1'b1; we0 = 1'b1; mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            n_total++;
            if (obs !== 8'b1001_1000) $display("FAIL rvt_busy_%0d: got %b want %b", k, obs, 8'b1001_1000);
            else n_pass++;
        end
        tick();
        mem_ready = 1'b1;
        #1;
        n_total++;
        if (obs !== 8'b1001_1100) $display("FAIL rvt_done: got %b want %b", obs, 8'b1001_1100);
        else n_pass++;
        req0 = 1'b0;
        tick();
        mem_ready = 1'b0;
        #1;
        n_total++;
        if (obs !== 8'b0000_0000) $display("FAIL rvt_no_timeout: got %b want %b", obs, 8'b0000_0000);
        else n_pass++;
    endtask

    task automatic test_reset_mid_busy();
        req1 = 1'b1; we1 = 1'b1;
        tick(); #1;
        n_total++;
        if (obs !== 8'b0111_1000) $display("FAIL rst_pre_busy: got %b want %b", obs, 8'b0111_1000);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (obs !== 8'b0000_0000) $display("FAIL rst_async: got %b want %b", obs, 8'b0000_0000);
        else n_pass++;
        req0 = 1'b1; we0 = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); #1;
        n_total++;
        if (obs !== 8'b1001_0000) $display("FAIL rst_first_tie: got %b want %b", obs, 8'b1001_0000);
        else n_pass++;
        req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b1;
        #1;
        n_total++;
        if (obs !== 8'b1001_0100) $display("FAIL rst_tie_done: got %b want %b", obs, 8'b1001_0100);
        else n_pass++;
        tick();
        mem_ready = 1'b0;
        #1;
    endtask

    task automatic test_ignore_changes();
        req0 = 1'b1; we0 = 1'b1;
        tick(); #1;
        n_total++;
        if (obs !== 8'b1001_1000) $display("FAIL ign_busy: got %b want %b", obs, 8'b1001_1000);
        else n_pass++;
        req0 = 1'b0; we0 = 1'b0;
        tick(); #1;
        n_total++;
        if (obs !== 8'b1001_1000) $display("FAIL ign_req_drop: got %b want %b", obs, 8'b1001_1000);
        else n_pass++;
        we0 = 1'b1;
        tick();
        we0 = 1'b0;
        #1;
        n_total++;
        if (obs !== 8'b1001_1000) $display("FAIL ign_we_toggle: got %b want %b", obs, 8'b1001_1000);
        else n_pass++;
        mem_ready = 1'b1;
        #1;
        n_total++;
        if (obs !== 8'b1001_1100) $display("FAIL ign_done: got %b want %b", obs, 8'b1001_1100);
        else n_pass++;
        tick(); #1;
        n_total++;
        if (obs !== 8'b0000_0000) $display("FAIL ign_idle_ready: got %b want %b", obs, 8'b0000_0000);
        else n_pass++;
        tick(); #1;
        n_total++;
        if (obs !== 8'b0000_0000) $display("FAIL ign_idle_stays: got %b want %b", obs, 8'b0000_0000);
        else n_pass++;
        mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_timeout();
        test_ready_vs_timeout();
        test_reset_mid_busy();
        test_ignore_changes();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
